// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI encodings, widths, FSM states and address helpers
//
// Contents: ID/ADDR/DATA/STRB/LEN widths, burst and resp encodings,
// read/write FSM state enums, transaction legality check and per-beat address step.
package axi_pkg;

   localparam int ID_W   = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;
   localparam int STRB_W = 8;
   localparam int LEN_W  = 8;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {R_IDLE, R_READ, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   // WRAP and the reserved encoding are serviced like INCR but flagged;
   // oversize beats are serviced as 8 bytes but flagged.
   function automatic logic txn_illegal(input logic [1:0] burst, input logic [2:0] size);
      return (burst == BURST_WRAP) || (burst == 2'b11) || (size > 3'd3);
   endfunction

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [2:0]        size,
                                                    input logic [1:0]        burst);
      logic [2:0] eff_size;
      eff_size = (size > 3'd3) ? 3'd3 : size;
      if (burst == BURST_FIXED)
         return addr;
      return addr + (ADDR_W'(1) << eff_size);
   endfunction

endpackage

// File: rtl/axi_ram_bank.sv
// rtl/axi_ram_bank.sv - 64-bit byte-writable RAM, one sync read port, one write port
//
// Ports: clock, reset (async, clears only the read register), rd_en/rd_addr/rd_data
// (data valid the cycle after rd_en), wr_en/wr_addr/wr_data/wr_strb (byte enables).
module axi_ram_bank
   import axi_pkg::*;
#(
   parameter int ADDR_BITS = 12
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 rd_en,
   input  logic [ADDR_BITS-1:0] rd_addr,
   output logic [DATA_W-1:0]    rd_data,
   input  logic                 wr_en,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic [DATA_W-1:0]    wr_data,
   input  logic [STRB_W-1:0]    wr_strb
);

   logic [DATA_W-1:0] mem [0:(1 << ADDR_BITS)-1];

   // Contents are deliberately not reset.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b])
               mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   // Same-word read and write in one cycle returns the pre-write word.
   // The register only loads on rd_en so read data stays put while a beat stalls.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         rd_data <= '0;
      else if (rd_en)
         rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/axi_ram_responder.sv
// rtl/axi_ram_responder.sv - AXI4 slave serving a 64-bit master from on-chip RAM
//
// Ports: clock, reset (async active-high); SAXI_aw*/SAXI_w*/SAXI_b* write address,
// data and response channels; SAXI_ar*/SAXI_r* read address and data channels.
// FIXED/INCR bursts, 1-8 byte sizes, one outstanding transaction per direction.
module axi_ram_responder
   import axi_pkg::*;
#(
   parameter int ADDR_BITS = 12
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ID_W-1:0]   SAXI_awid,
   input  logic [ADDR_W-1:0] SAXI_awaddr,
   input  logic [LEN_W-1:0]  SAXI_awlen,
   input  logic [2:0]        SAXI_awsize,
   input  logic [1:0]        SAXI_awburst,
   input  logic              SAXI_awvalid,
   output logic              SAXI_awready,
   input  logic [DATA_W-1:0] SAXI_wdata,
   input  logic [STRB_W-1:0] SAXI_wstrb,
   input  logic              SAXI_wlast,
   input  logic              SAXI_wvalid,
   output logic              SAXI_wready,
   output logic [ID_W-1:0]   SAXI_bid,
   output logic [1:0]        SAXI_bresp,
   output logic              SAXI_bvalid,
   input  logic              SAXI_bready,
   input  logic [ID_W-1:0]   SAXI_arid,
   input  logic [ADDR_W-1:0] SAXI_araddr,
   input  logic [LEN_W-1:0]  SAXI_arlen,
   input  logic [2:0]        SAXI_arsize,
   input  logic [1:0]        SAXI_arburst,
   input  logic              SAXI_arvalid,
   output logic              SAXI_arready,
   output logic [ID_W-1:0]   SAXI_rid,
   output logic [DATA_W-1:0] SAXI_rdata,
   output logic [1:0]        SAXI_rresp,
   output logic              SAXI_rlast,
   output logic              SAXI_rvalid,
   input  logic              SAXI_rready
);

   r_state_t          r_state, r_next;
   logic [ID_W-1:0]   r_id;
   logic [ADDR_W-1:0] r_addr;
   logic [LEN_W-1:0]  r_len, r_beat;
   logic [2:0]        r_size;
   logic [1:0]        r_burst;
   logic              r_err;
   logic              ram_rd_en;

   w_state_t          w_state, w_next;
   logic [ID_W-1:0]   w_id;
   logic [ADDR_W-1:0] w_addr;
   logic [LEN_W-1:0]  w_len, w_beat;
   logic [2:0]        w_size;
   logic [1:0]        w_burst;
   logic              w_err;
   logic              ram_wr_en;

   axi_ram_bank #(.ADDR_BITS(ADDR_BITS)) u_bank (
      .clock   (clock),
      .reset   (reset),
      .rd_en   (ram_rd_en),
      .rd_addr (r_addr[ADDR_BITS+2:3]),
      .rd_data (SAXI_rdata),
      .wr_en   (ram_wr_en),
      .wr_addr (w_addr[ADDR_BITS+2:3]),
      .wr_data (SAXI_wdata),
      .wr_strb (SAXI_wstrb)
   );

   // ---------------- read channel ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_state <= R_IDLE;
      else
         r_state <= r_next;
   end

   always_comb begin
      r_next       = r_state;
      SAXI_arready = 1'b0;
      SAXI_rvalid  = 1'b0;
      SAXI_rlast   = 1'b0;
      ram_rd_en    = 1'b0;
      case (r_state)
         R_IDLE: begin
            SAXI_arready = 1'b1;
            if (SAXI_arvalid)
               r_next = R_READ;
         end
         R_READ: begin
            ram_rd_en = 1'b1;
            r_next    = R_DATA;
         end
         R_DATA: begin
            SAXI_rvalid = 1'b1;
            SAXI_rlast  = (r_beat == r_len);
            if (SAXI_rready)
               r_next = (r_beat == r_len) ? R_IDLE : R_READ;
         end
         default: r_next = R_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_id    <= '0;
         r_addr  <= '0;
         r_len   <= '0;
         r_beat  <= '0;
         r_size  <= '0;
         r_burst <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (SAXI_arvalid) begin
                  r_id    <= SAXI_arid;
                  r_addr  <= SAXI_araddr;
                  r_len   <= SAXI_arlen;
                  r_size  <= SAXI_arsize;
                  r_burst <= SAXI_arburst;
                  r_beat  <= '0;
                  r_err   <= txn_illegal(SAXI_arburst, SAXI_arsize);
               end
            end
            R_DATA: begin
               if (SAXI_rready && (r_beat != r_len)) begin
                  r_addr <= next_addr(r_addr, r_size, r_burst);
                  r_beat <= r_beat + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign SAXI_rid   = r_id;
   assign SAXI_rresp = r_err ? RESP_SLVERR : RESP_OKAY;

   // ---------------- write channel ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         w_state <= W_IDLE;
      else
         w_state <= w_next;
   end

   always_comb begin
      w_next       = w_state;
      SAXI_awready = 1'b0;
      SAXI_wready  = 1'b0;
      SAXI_bvalid  = 1'b0;
      ram_wr_en    = 1'b0;
      case (w_state)
         W_IDLE: begin
            SAXI_awready = 1'b1;
            if (SAXI_awvalid)
               w_next = W_DATA;
         end
         W_DATA: begin
            SAXI_wready = 1'b1;
            if (SAXI_wvalid) begin
               ram_wr_en = 1'b1;
               // Beat count, not wlast, ends the burst.
               if (w_beat == w_len)
                  w_next = W_RESP;
            end
         end
         W_RESP: begin
            SAXI_bvalid = 1'b1;
            if (SAXI_bready)
               w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         w_id    <= '0;
         w_addr  <= '0;
         w_len   <= '0;
         w_beat  <= '0;
         w_size  <= '0;
         w_burst <= '0;
         w_err   <= 1'b0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (SAXI_awvalid) begin
                  w_id    <= SAXI_awid;
                  w_addr  <= SAXI_awaddr;
                  w_len   <= SAXI_awlen;
                  w_size  <= SAXI_awsize;
                  w_burst <= SAXI_awburst;
                  w_beat  <= '0;
                  w_err   <= txn_illegal(SAXI_awburst, SAXI_awsize);
               end
            end
            W_DATA: begin
               if (SAXI_wvalid) begin
                  w_addr <= next_addr(w_addr, w_size, w_burst);
                  w_beat <= w_beat + 1'b1;
                  if (SAXI_wlast != (w_beat == w_len))
                     w_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign SAXI_bid   = w_id;
   assign SAXI_bresp = ((w_state == W_RESP) && w_err) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_ram_responder.sv
// tb/tb_axi_ram_responder.sv - self-checking bench for axi_ram_responder
module tb_axi_ram_responder;

   localparam int AB    = 12;
   localparam int LIMIT = 64;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid;
   logic        SAXI_awready;
   logic [63:0] wdata;
   logic [7:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        SAXI_wready;
   logic [3:0]  SAXI_bid;
   logic [1:0]  SAXI_bresp;
   logic        SAXI_bvalid;
   logic        bready;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        SAXI_arready;
   logic [3:0]  SAXI_rid;
   logic [63:0] SAXI_rdata;
   logic [1:0]  SAXI_rresp;
   logic        SAXI_rlast;
   logic        SAXI_rvalid;
   logic        rready;

   int n_assert = 0;
   int n_fail   = 0;
   int cnt;

   logic [63:0] model_mem [0:(1 << AB)-1];
   logic [63:0] wbuf [0:15];
   logic [7:0]  sbuf [0:15];
   logic [63:0] rd;

   axi_ram_responder #(.ADDR_BITS(AB)) dut (
      .clock        (clock),
      .reset        (reset),
      .SAXI_awid    (awid),
      .SAXI_awaddr  (awaddr),
      .SAXI_awlen   (awlen),
      .SAXI_awsize  (awsize),
      .SAXI_awburst (awburst),
      .SAXI_awvalid (awvalid),
      .SAXI_awready (SAXI_awready),
      .SAXI_wdata   (wdata),
      .SAXI_wstrb   (wstrb),
      .SAXI_wlast   (wlast),
      .SAXI_wvalid  (wvalid),
      .SAXI_wready  (SAXI_wready),
      .SAXI_bid     (SAXI_bid),
      .SAXI_bresp   (SAXI_bresp),
      .SAXI_bvalid  (SAXI_bvalid),
      .SAXI_bready  (bready),
      .SAXI_arid    (arid),
      .SAXI_araddr  (araddr),
      .SAXI_arlen   (arlen),
      .SAXI_arsize  (arsize),
      .SAXI_arburst (arburst),
      .SAXI_arvalid (arvalid),
      .SAXI_arready (SAXI_arready),
      .SAXI_rid     (SAXI_rid),
      .SAXI_rdata   (SAXI_rdata),
      .SAXI_rresp   (SAXI_rresp),
      .SAXI_rlast   (SAXI_rlast),
      .SAXI_rvalid  (SAXI_rvalid),
      .SAXI_rready  (rready)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] bstep(input logic [31:0] a, input logic [2:0] size,
                                         input logic [1:0] burst);
      int bytes;
      bytes = 1 << ((size > 3'd3) ? 3 : int'(size));
      return (burst == 2'b00) ? a : a + 32'(bytes);
   endfunction

   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int bad, input int bdelay);
      logic [31:0] a;
      logic        exp_err;
      int          c;
      exp_err = (burst >= 2'd2) || (size > 3'd3);
      awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
      c = 0;
      while (!SAXI_awready && c < LIMIT) begin @(posedge clock); #1; c++; end
      check("aw_wait", c < LIMIT, 1);
      @(posedge clock); #1;
      awvalid = 1'b0;
      check("wready_rise", SAXI_wready, 1);
      check("awready_busy", SAXI_awready, 0);
      a = addr;
      for (int i = 0; i <= len; i++) begin
         wdata = wbuf[i]; wstrb = sbuf[i];
         wlast = (i == len) ^ (i == bad);
         wvalid = 1'b1;
         if (i == bad) exp_err = 1'b1;
         c = 0;
         while (!SAXI_wready && c < LIMIT) begin @(posedge clock); #1; c++; end
         check("w_wait", c < LIMIT, 1);
         @(posedge clock); #1;
         wvalid = 1'b0; wlast = 1'b0;
         for (int b = 0; b < 8; b++)
            if (sbuf[i][b]) model_mem[a[AB+2:3]][8*b +: 8] = wbuf[i][8*b +: 8];
         a = bstep(a, size, burst);
         if (i < len && $urandom_range(0, 3) == 0) begin @(posedge clock); #1; end
      end
      check("bvalid_rise", SAXI_bvalid, 1);
      check("bid", SAXI_bid, id);
      check("bresp", SAXI_bresp, exp_err ? 2'b10 : 2'b00);
      check("wready_after", SAXI_wready, 0);
      for (int k = 0; k < bdelay; k++) begin
         @(posedge clock); #1;
         check("bvalid_hold", SAXI_bvalid, 1);
      end
      bready = 1'b1;
      @(posedge clock); #1;
      bready = 1'b0;
      check("bvalid_clear", SAXI_bvalid, 0);
      check("awready_back", SAXI_awready, 1);
   endtask

   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input bit stall, input bit chk_lat, output logic [63:0] last);
      logic [31:0] a;
      logic [63:0] held;
      logic [1:0]  exp_resp;
      int          c;
      exp_resp = ((burst >= 2'd2) || (size > 3'd3)) ? 2'b10 : 2'b00;
      last = '0;
      arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
      c = 0;
      while (!SAXI_arready && c < LIMIT) begin @(posedge clock); #1; c++; end
      check("ar_wait", c < LIMIT, 1);
      @(posedge clock); #1;
      arvalid = 1'b0;
      if (chk_lat) begin
         check("rvalid_T1", SAXI_rvalid, 0);
         check("arready_busy", SAXI_arready, 0);
      end
      a = addr;
      for (int i = 0; i <= len; i++) begin
         c = 0;
         while (!SAXI_rvalid && c < LIMIT) begin @(posedge clock); #1; c++; end
         check("r_wait", c < LIMIT, 1);
         if (chk_lat && i == 0) check("rvalid_T2", c, 1);
         check("rdata", SAXI_rdata, model_mem[a[AB+2:3]]);
         check("rlast", SAXI_rlast, i == len);
         check("rid", SAXI_rid, id);
         check("rresp", SAXI_rresp, exp_resp);
         held = SAXI_rdata;
         if (stall) begin
            while ($urandom_range(0, 1) == 1) begin
               rready = 1'b0;
               @(posedge clock); #1;
               check("rdata_stall", SAXI_rdata, held);
               check("rvalid_stall", SAXI_rvalid, 1);
            end
         end
         last = SAXI_rdata;
         rready = 1'b1;
         @(posedge clock); #1;
         rready = 1'b0;
         check("rvalid_gap", SAXI_rvalid, 0);
         a = bstep(a, size, burst);
      end
      check("arready_back", SAXI_arready, 1);
   endtask

   initial begin
      reset = 1'b1;
      awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
      wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
      arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0; rready = 0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_awready", SAXI_awready, 1);
      check("rst_arready", SAXI_arready, 1);
      check("rst_wready", SAXI_wready, 0);
      check("rst_bvalid", SAXI_bvalid, 0);
      check("rst_rvalid", SAXI_rvalid, 0);
      check("rst_rlast", SAXI_rlast, 0);
      check("rst_bid", SAXI_bid, 0);
      check("rst_bresp", SAXI_bresp, 0);
      check("rst_rid", SAXI_rid, 0);
      check("rst_rresp", SAXI_rresp, 0);
      check("rst_rdata", SAXI_rdata, 0);
      reset = 1'b0;
      @(posedge clock); #1;

      // single write then read
      wbuf[0] = 64'h1122334455667788; sbuf[0] = 8'hFF;
      do_write(4'h3, 32'h100, 0, 3'd3, 2'b01, -1, 0);
      do_read(4'h6, 32'h100, 0, 3'd3, 2'b01, 1'b0, 1'b1, rd);
      check("single_data", rd, 64'h1122334455667788);

      // INCR burst with random rready stalls
      for (int i = 0; i < 4; i++) begin wbuf[i] = 64'(i); sbuf[i] = 8'hFF; end
      do_write(4'h1, 32'h200, 3, 3'd3, 2'b01, -1, 2);
      do_read(4'h2, 32'h200, 3, 3'd3, 2'b01, 1'b1, 1'b0, rd);
      check("incr_last_beat", rd, 64'd3);

      // byte strobe
      wbuf[0] = '1; sbuf[0] = 8'hFF;
      do_write(4'h4, 32'h300, 0, 3'd3, 2'b01, -1, 0);
      wbuf[0] = '0; sbuf[0] = 8'h0F;
      do_write(4'h5, 32'h300, 0, 3'd3, 2'b01, -1, 1);
      do_read(4'h7, 32'h300, 0, 3'd3, 2'b01, 1'b0, 1'b0, rd);
      check("strobe_word", rd, 64'hFFFF_FFFF_0000_0000);

      // protocol errors
      for (int i = 0; i < 2; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
      do_write(4'h7, 32'h380, 1, 3'd3, 2'b01, 0, 0);
      do_write(4'hA, 32'h380, 0, 3'd3, 2'b10, -1, 0);
      do_read(4'h8, 32'h200, 1, 3'd3, 2'b11, 1'b0, 1'b0, rd);
      do_read(4'h9, 32'h200, 1, 3'd6, 2'b01, 1'b0, 1'b0, rd);

      // FIXED burst
      for (int i = 0; i < 4; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'(1 << i) | 8'hF0; end
      do_write(4'h2, 32'h480, 3, 3'd3, 2'b00, -1, 0);
      do_read(4'h3, 32'h480, 2, 3'd3, 2'b00, 1'b1, 1'b0, rd);

      // preload words 0..7 and a scratch region for random narrow traffic
      for (int i = 0; i < 16; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
      do_write(4'h0, 32'h0, 7, 3'd3, 2'b01, -1, 0);
      for (int i = 0; i < 16; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
      do_write(4'h0, 32'h4000, 15, 3'd3, 2'b01, -1, 0);

      // random narrow/aliased transactions
      for (int t = 0; t < 8; t++) begin
         logic [31:0] ra;
         logic [2:0]  rs;
         logic [1:0]  rb;
         int          rl;
         ra = ($urandom & 32'hFFFF_8000) | (32'h4000 + 32'($urandom_range(0, 63)));
         rs = 3'($urandom_range(0, 3));
         rb = 2'($urandom_range(0, 1));
         rl = $urandom_range(0, 5);
         for (int i = 0; i < 16; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'($urandom); end
         do_write(4'($urandom), ra, rl, rs, rb, -1, $urandom_range(0, 2));
         do_read(4'($urandom), ra, rl, rs, rb, 1'b1, 1'b0, rd);
      end

      // concurrent read and write
      for (int i = 0; i < 8; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
      fork
         do_read(4'hA, 32'h0, 7, 3'd3, 2'b01, 1'b1, 1'b0, rd);
         do_write(4'hB, 32'h1000, 7, 3'd3, 2'b01, -1, 5);
      join
      do_read(4'hC, 32'h1000, 7, 3'd3, 2'b01, 1'b0, 1'b0, rd);

      // reset during beat 2 of a len 7 read
      arid = 4'h5; araddr = 32'h0; arlen = 8'd7; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
      @(posedge clock); #1;
      arvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cnt = 0;
         while (!SAXI_rvalid && cnt < LIMIT) begin @(posedge clock); #1; cnt++; end
         check("rst_burst_wait", cnt < LIMIT, 1);
         check("rst_burst_data", SAXI_rdata, model_mem[i]);
         if (i < 2) begin
            rready = 1'b1;
            @(posedge clock); #1;
            rready = 1'b0;
         end
      end
      #2 reset = 1'b1;
      #1;
      check("async_rvalid", SAXI_rvalid, 0);
      check("async_rlast", SAXI_rlast, 0);
      check("async_rdata", SAXI_rdata, 0);
      check("async_rid", SAXI_rid, 0);
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #1;
      check("post_arready", SAXI_arready, 1);
      check("post_awready", SAXI_awready, 1);
      check("post_rvalid", SAXI_rvalid, 0);
      check("post_bvalid", SAXI_bvalid, 0);
      do_read(4'hD, 32'h100, 0, 3'd3, 2'b01, 1'b0, 1'b1, rd);
      check("post_reset_data", rd, 64'h1122334455667788);
      do_read(4'hE, 32'h0, 7, 3'd3, 2'b01, 1'b1, 1'b0, rd);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_ram_responder.md
# axi_ram_responder

AXI4 slave that services the CPU core's 64-bit master port from an on-chip byte-writable RAM, with independent read and write channels. It is the memory end of the core's AXI interface in simulation and FPGA tops. Bursts are FIXED and INCR, sizes 1–8 bytes, and at most one outstanding transaction per direction.

## Interface
- `ADDR_BITS`, default 12: log2 of RAM depth in 64-bit words (default 32 KiB).
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `SAXI_awid` in 4, `SAXI_awaddr` in 32, `SAXI_awlen` in 8, `SAXI_awsize` in 3, `SAXI_awburst` in 2, `SAXI_awvalid` in 1: write address channel.
- `SAXI_awready` out 1: write address accept.
- `SAXI_wdata` in 64, `SAXI_wstrb` in 8, `SAXI_wlast` in 1, `SAXI_wvalid` in 1: write data channel.
- `SAXI_wready` out 1: write data accept.
- `SAXI_bid` out 4, `SAXI_bresp` out 2, `SAXI_bvalid` out 1: write response.
- `SAXI_bready` in 1: write response accept.
- `SAXI_arid` in 4, `SAXI_araddr` in 32, `SAXI_arlen` in 8, `SAXI_arsize` in 3, `SAXI_arburst` in 2, `SAXI_arvalid` in 1: read address channel.
- `SAXI_arready` out 1: read address accept.
- `SAXI_rid` out 4, `SAXI_rdata` out 64, `SAXI_rresp` out 2, `SAXI_rlast` out 1, `SAXI_rvalid` out 1: read data channel.
- `SAXI_rready` in 1: read data accept.

## Operation
- Word index is `addr[ADDR_BITS+2:3]`. Higher address bits are ignored, so accesses alias modulo RAM size.
- Address step per beat:
  - INCR (2'b01): `addr + (1 << size)`, 32-bit wrap.
  - FIXED (2'b00): no step.
  - WRAP (2'b10) and reserved (2'b11): handled as INCR, but the transaction's resp is SLVERR (2'b10).
- `size > 3` is also handled as `size = 3`, with resp SLVERR.
- Read FSM:
  - R_IDLE: `arready = 1`. On the ar handshake, latch id, addr, len, size, burst; clear the beat counter; go to R_READ.
  - R_READ: issue the RAM read for the current word; go to R_DATA.
  - R_DATA: `rvalid = 1`; rdata is the full 64-bit word, held stable until handshake. `rlast = (beat == len)`. On handshake: if rlast, go to R_IDLE; otherwise step the address, increment beat, go to R_READ.
- Write FSM:
  - W_IDLE: `awready = 1`. On the aw handshake, latch the fields, clear beat and error flag; go to W_DATA.
  - W_DATA: `wready = 1`. On each w handshake, write the bytes whose wstrb bit is set, then step the address and increment beat.
  - If `wlast != (beat == len)` on any beat, set the error flag.
  - The burst terminates on `beat == len` regardless of wlast; go to W_RESP.
  - W_RESP: `bvalid = 1`, `bid` = latched id, `bresp` = SLVERR if the error flag or an illegal burst/size is present, else OKAY. On bready, go to W_IDLE.
- Channels are fully independent and may be active at the same time.
- RAM conflicts: a read and a write to the same word in the same cycle returns the old data.
- Reset:
  - Both FSMs go to IDLE and all latches and counters clear.
  - RAM contents are not reset.
  - Reset asserted mid-burst aborts the burst silently; no response is issued.

## Timing
- Reset values: `awready = 1`, `arready = 1`. `wready`, `bvalid`, `rvalid`, `rlast` are 0. `bid`, `bresp`, `rid`, `rresp`, `rdata` are 0.
- Read latency: ar handshake at cycle T gives the first `rvalid` at T+2. After each beat handshake, the next `rvalid` follows 2 cycles later, so peak throughput is one beat per 2 cycles.
- Write: `wready` rises the cycle after the aw handshake, giving one beat per cycle. `bvalid` rises the cycle after the final w handshake.
- All outputs are registered or decoded from state only; there are no combinational input-to-output paths.
- `arready` and `awready` are 0 whenever the corresponding FSM is not IDLE.

## Structure
- Shared package `axi_pkg`:
  - burst encodings FIXED/INCR/WRAP;
  - resp encodings OKAY/SLVERR;
  - widths ID_W = 4, ADDR_W = 32, DATA_W = 64, STRB_W = 8, LEN_W = 8;
  - read and write FSM state enums.
- Sub-module `axi_ram_bank`: 1 read port and 1 write port, 2^ADDR_BITS × 64-bit words, byte-enable write, synchronous read with 1-cycle latency.

## Test plan
- Single write then read:
  - Stimulus: aw addr 0x100, len 0, size 3, INCR; w data 0x1122334455667788, strb 0xFF, wlast 1; then ar at the same address.
  - Required: bresp OKAY with the matching bid; rdata 0x1122334455667788; rlast 1; rvalid at T+2.
- INCR burst:
  - Stimulus: write len 3 at 0x200, data 0..3; read back with len 3, with rready toggled 1/0 randomly.
  - Required: 4 beats 0..3 in order, rlast only on beat 3, rdata stable while stalled.
- Byte strobe:
  - Stimulus: preload 0xFFFF_FFFF_FFFF_FFFF; write 0 with strb 0x0F.
  - Required: read returns 0xFFFF_FFFF_0000_0000.
- Protocol errors:
  - Stimulus: a len 1 write with wlast on beat 0; separately an arburst 2'b11 read.
  - Required: the write's bresp SLVERR after 2 beats; the read's rresp SLVERR.
- Concurrency:
  - Stimulus: simultaneous len 7 read at 0x0 and len 7 write at 0x1000; hold bready low for 5 cycles.
  - Required: both complete with correct data; bvalid held until bready.
- Reset mid-burst:
  - Stimulus: assert reset during beat 2 of a len 7 read.
  - Required: rvalid drops asynchronously; `arready = 1` after release; earlier writes are still readable.
